// File: rtl/serial_adder_sequencer.sv
// Digit-serial adder: a WIDTH-bit sum computed DIGIT bits per cycle with a registered carry.
// Optional subtract mode (sum = a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_sequencer #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one digit added per cycle
  // DONE  | result presented, waiting for out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int N_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] sum_shift;
  logic             sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign dsum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the MSB so after N_DIGITS shifts the LSB digit lands at the bottom.
  generate
    if (WIDTH == DIGIT) begin : g_single
      assign sum_shift = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign sum_shift = {dsum[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub_eff ? ~b : b;
          carry_d = sub_eff;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          carry_out_d = dsum[DIGIT];
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Randomized bench for serial_adder_sequencer against an arithmetic reference model.
// Covers the 32/8 default instance and a single-digit 8/8 instance.
module tb_serial_adder_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, carry_out, busy;
  logic [31:0] sum;
  logic        sub;

  logic        in_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        in_ready8, out_valid8, carry_out8, busy8, sub8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_adder_sequencer #(.WIDTH(32), .DIGIT(8)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .busy(busy)
  );

  serial_adder_sequencer #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .carry_out(carry_out8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on 33-bit values.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] r;
    if (s) begin
      r[31:0] = x - y;
      r[32]   = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, input int stall);
    logic [32:0] exp;
    logic [31:0] held;
    int lat;
`ifdef SERIAL_ADDER_SUB_EN
    exp = model(av, bv, sv);
`else
    exp = model(av, bv, 1'b0);
`endif
    @(negedge clock);
    chk("rdy_idle", {63'd0, in_ready}, 64'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = ~sv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("sum", {32'd0, sum}, {32'd0, exp[31:0]});
    chk("carry", {63'd0, carry_out}, {63'd0, exp[32]});
    held = sum;
    in_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_sum", {32'd0, sum}, {32'd0, held});
      chk("bp_busy", {63'd0, busy}, 64'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rdy_after", {63'd0, in_ready}, 64'd1);
    chk("valid_after", {63'd0, out_valid}, 64'd0);
    chk("hold_sum", {32'd0, sum}, {32'd0, exp[31:0]});
    chk("hold_carry", {63'd0, carry_out}, {63'd0, exp[32]});
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, av} + {1'b0, bv};
    @(negedge clock);
    a8 = av; b8 = bv; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("lat8", 64'(lat), 64'd1);
    chk("sum8", {56'd0, sum8}, {56'd0, exp[7:0]});
    chk("carry8", {63'd0, carry_out8}, {63'd0, exp[8]});
    out_ready8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready8 = 1'b0;
    chk("rdy8", {63'd0, in_ready8}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_carry", {63'd0, carry_out}, 64'd0);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5);

    // Abort mid-RUN when the digit counter has reached 2.
    @(negedge clock);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sum", {32'd0, sum}, 64'd0);
    chk("abort_carry", {63'd0, carry_out}, 64'd0);
    run_op(32'd3, 32'd4, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(32'd5, 32'd7, 1'b1, 0);
    run_op(32'd7, 32'd5, 1'b1, 0);
    run_op(32'd7, 32'd5, 1'b0, 0);
`endif

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) rb = ~ra;
      if (n % 7 == 0) ra = 32'hFFFF_FFFF;
`ifdef SERIAL_ADDER_SUB_EN
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
`else
      run_op(ra, rb, 1'b0, $urandom_range(0, 3));
`endif
    end

    run_op8(8'h80, 8'h80);
    run_op8(8'h12, 8'h34);
    run_op8(8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
